// File: rtl/iterative_alu_unit_pkg.sv
// Shared ALU select codes and flag bundle for the iterative execute-stage ALU.
package iterative_alu_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_sel_e;

  typedef struct packed {
    logic zf;
    logic cf;
    logic vf;
    logic sf;
  } alu_flags_t;

  function automatic logic is_shift(input logic [3:0] sel);
    return sel inside {ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction

endpackage

// File: rtl/iterative_alu_unit_addsub.sv
// Shared adder/subtractor: sub=1 computes a + ~b + 1, so cf=1 means no borrow.
module iterative_alu_unit_addsub #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sub,
  output logic [XLEN-1:0] sum,
  output logic            cf,
  output logic            vf
);

  logic [XLEN-1:0] b_eff;

  assign b_eff     = sub ? ~b : b;
  assign {cf, sum} = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
  // Signed overflow: both addends share a sign that the sum does not.
  assign vf        = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);

endmodule

// File: rtl/iterative_alu_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic, iterative shifter of
// SHIFT_STEP bits per cycle, valid/ready on both sides, registered result+flags.
module iterative_alu_unit
  import iterative_alu_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            cf,
  output logic            vf,
  output logic            sf,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_e          state_q, state_d;
  logic [XLEN-1:0] shreg_q, shift_nxt;
  logic [4:0]      count_q, step_k;
  logic [3:0]      shop_q;
  logic [XLEN-1:0] result_q;
  alu_flags_t      flags_q;

  logic            accept;
  logic [XLEN-1:0] as_sum, alu_res;
  logic            as_cf, as_vf, alu_cf, alu_vf;

  iterative_alu_unit_addsub #(.XLEN(XLEN)) u_alu_addsub (
    .a   (op_a),
    .b   (op_b),
    .sub (alu_sel != ALU_ADD),
    .sum (as_sum),
    .cf  (as_cf),
    .vf  (as_vf)
  );

  assign accept = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    case (alu_sel)
      ALU_ADD, ALU_SUB: begin
        alu_res = as_sum;
        alu_cf  = as_cf;
        alu_vf  = as_vf;
      end
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, as_sum[XLEN-1] ^ as_vf};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, ~as_cf};
      default:  alu_res = '0;
    endcase
  end

  // Last step clamps to the remaining count; SRA keeps replicating the original sign bit.
  always_comb begin
    step_k = (count_q < STEP) ? count_q : STEP;
    case (shop_q)
      ALU_SLL: shift_nxt = shreg_q << step_k;
      ALU_SRA: shift_nxt = $signed(shreg_q) >>> step_k;
      default: shift_nxt = shreg_q >> step_k;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = (is_shift(alu_sel) && op_b[4:0] != 5'd0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (flush)                  state_d = IDLE;
        else if (count_q == step_k) state_d = DONE;
      end
      DONE: if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      count_q  <= '0;
      shop_q   <= ALU_ADD;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (is_shift(alu_sel)) begin
          shreg_q <= op_a;
          count_q <= op_b[4:0];
          shop_q  <= alu_sel;
          if (op_b[4:0] == 5'd0) begin
            result_q <= op_a;
            flags_q  <= '{zf: (op_a == '0), cf: 1'b0, vf: 1'b0, sf: op_a[XLEN-1]};
          end
        end else begin
          result_q <= alu_res;
          flags_q  <= '{zf: (alu_res == '0), cf: alu_cf, vf: alu_vf, sf: alu_res[XLEN-1]};
        end
      end else if (state_q == SHIFT && !flush) begin
        shreg_q <= shift_nxt;
        count_q <= count_q - step_k;
        if (count_q == step_k) begin
          result_q <= shift_nxt;
          flags_q  <= '{zf: (shift_nxt == '0), cf: 1'b0, vf: 1'b0, sf: shift_nxt[XLEN-1]};
        end
      end
    end
  end

  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign zf        = flags_q.zf;
  assign cf        = flags_q.cf;
  assign vf        = flags_q.vf;
  assign sf        = flags_q.sf;

endmodule

// File: tb/tb_iterative_alu_unit.sv
// Self-checking bench for iterative_alu_unit: directed scenarios plus random ops
// compared against an arithmetic reference model.
module tb_iterative_alu_unit;
  import iterative_alu_unit_pkg::*;

  localparam int STEP = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_sel = 4'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zf, cf, vf, sf, busy;

  int tests = 0;
  int fails = 0;

  iterative_alu_unit #(.XLEN(32), .SHIFT_STEP(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_sel   (alu_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zf        (zf),
    .cf        (cf),
    .vf        (vf),
    .sf        (sf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;  // {zf, cf, vf, sf}
    int          lat;
  } exp_t;

  function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, wide;
    int     sh;
    logic   c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    c = 1'b0;
    v = 1'b0;
    e.lat = 1;
    case (sel)
      ALU_ADD: begin
        e.res = a + b;
        c = (longint'(a) + longint'(b)) > 64'h0000_0000_FFFF_FFFF;
        wide = sa + sb;
        v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      ALU_SUB: begin
        e.res = a - b;
        c = (a >= b);
        wide = sa - sb;
        v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      ALU_AND:  e.res = a & b;
      ALU_OR:   e.res = a | b;
      ALU_XOR:  e.res = a ^ b;
      ALU_SLL:  begin e.res = a << sh; e.lat = 1 + (sh + STEP - 1) / STEP; end
      ALU_SRL:  begin e.res = a >> sh; e.lat = 1 + (sh + STEP - 1) / STEP; end
      ALU_SRA:  begin e.res = $signed(a) >>> sh; e.lat = 1 + (sh + STEP - 1) / STEP; end
      ALU_SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
      default:  e.res = 32'd0;
    endcase
    e.flags = {(e.res == 32'd0), c, v, e.res[31]};
    return e;
  endfunction

  // Drives one request with out_ready=1, scrambles operands after accept, collects the response.
  task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] r, output logic [3:0] f, output bit hs_ok);
    @(negedge clk);
    alu_sel = sel; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
    hs_ok = (in_ready === 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; alu_sel = 4'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
    r = result;
    f = {zf, cf, vf, sf};
    @(posedge clk); #1;
  endtask

  task automatic test_single_op(input string name, input logic [3:0] sel, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r);
    exp_t       e;
    int         lat;
    logic [3:0] f;
    bit         hs_ok;
    e = model(sel, a, b);
    run_op(sel, a, b, lat, r, f, hs_ok);
    tests++;
    if (r !== e.res) begin
      fails++; $display("FAIL %s result: got %h expected %h", name, r, e.res);
    end
    tests++;
    if (f !== e.flags) begin
      fails++; $display("FAIL %s flags zcvs: got %b expected %b", name, f, e.flags);
    end
    tests++;
    if (lat != e.lat) begin
      fails++; $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
    end
    tests++;
    if (!hs_ok) begin
      fails++; $display("FAIL %s handshake: in_ready/busy wrong around op, got 0 expected 1", name);
    end
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({out_valid, busy, result, zf, cf, vf, sf} !== 38'd0) begin
      fails++; $display("FAIL reset outputs: got %h expected 0", {out_valid, busy, result, zf, cf, vf, sf});
    end
    @(negedge clk); rst = 1'b1; #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset release ready/valid: got %b%b expected 10", in_ready, out_valid);
    end
  endtask

  task automatic test_arith();
    logic [31:0] r;
    int          lat;
    logic [3:0]  f;
    bit          hs_ok;
    run_op(ALU_ADD, 32'h7FFF_FFFF, 32'd1, lat, r, f, hs_ok);
    tests++;
    if (r !== 32'h8000_0000 || f !== 4'b0011 || lat != 1) begin
      fails++; $display("FAIL add_ovf: got %h/%b/%0d expected 80000000/0011/1", r, f, lat);
    end
    test_single_op("sub_zero", ALU_SUB, 32'd5, 32'd5, r);
    tests++;
    if (r !== 32'd0) begin fails++; $display("FAIL sub_zero const: got %h expected 0", r); end
    test_single_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, r);
    tests++;
    if (r !== 32'd1) begin fails++; $display("FAIL slt const: got %h expected 1", r); end
    test_single_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, r);
    tests++;
    if (r !== 32'd0) begin fails++; $display("FAIL sltu const: got %h expected 0", r); end
    test_single_op("unknown_sel", 4'd13, 32'h1234, 32'h5678, r);
  endtask

  task automatic test_shift();
    logic [31:0] r;
    test_single_op("sra4", ALU_SRA, 32'h8000_0000, 32'd4, r);
    tests++;
    if (r !== 32'hF800_0000) begin fails++; $display("FAIL sra4 const: got %h expected f8000000", r); end
    test_single_op("srl0", ALU_SRL, 32'h8000_0000, 32'd0, r);
    test_single_op("sll31", ALU_SLL, 32'h0000_0003, 32'hFFFF_FFDF, r);
    test_single_op("sra31", ALU_SRA, 32'h4000_0000, 32'd31, r);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    alu_sel = ALU_ADD; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = 32'hDEAD; op_b = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) begin
        fails++; $display("FAIL stall cycle %0d: got v%b r%h rdy%b expected v1 r7 rdy0", i, out_valid, result, in_ready);
      end
      @(posedge clk); #1;
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd7) begin
      fails++; $display("FAIL stall release: got v%b rdy%b r%h expected v0 rdy1 r7", out_valid, in_ready, result);
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, r;
    bit          saw_valid;
    prev = result;
    saw_valid = 1'b0;
    @(negedge clk);
    alu_sel = ALU_SLL; op_a = 32'd1; op_b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    if (out_valid === 1'b1) saw_valid = 1'b1;
    tests++;
    if (saw_valid || busy !== 1'b0 || result !== prev) begin
      fails++; $display("FAIL flush_shift: got v%b busy%b r%h expected v0 busy0 r%h", saw_valid, busy, result, prev);
    end
    @(negedge clk); flush = 1'b0; #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b expected 1", in_ready); end

    // flush while idle blocks the accept
    @(negedge clk); alu_sel = ALU_ADD; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1; flush = 1'b1; #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_idle ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL flush_idle accept: got v%b busy%b expected v0 busy0", out_valid, busy);
    end
    @(negedge clk); in_valid = 1'b0; flush = 1'b0;

    // flush in DONE while stalled drops out_valid and keeps the result
    @(negedge clk); alu_sel = ALU_ADD; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || result !== 32'd2) begin
      fails++; $display("FAIL flush_done: got v%b r%h expected v0 r2", out_valid, result);
    end
    @(negedge clk); flush = 1'b0;

    test_single_op("add_after_flush", ALU_ADD, 32'd2, 32'd2, r);
    tests++;
    if (r !== 32'd4) begin fails++; $display("FAIL add_after_flush const: got %h expected 4", r); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    bit          saw_valid;
    saw_valid = 1'b0;
    @(negedge clk);
    alu_sel = ALU_SLL; op_a = 32'd1; op_b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b0; #1;
    tests++;
    if ({out_valid, busy, result, zf, cf, vf, sf} !== 38'd0) begin
      fails++; $display("FAIL async_reset outputs: got %h expected 0", {out_valid, busy, result, zf, cf, vf, sf});
    end
    @(negedge clk); rst = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 || in_ready !== 1'b1) saw_valid = 1'b1;
    end
    tests++;
    if (saw_valid) begin fails++; $display("FAIL async_reset discard: got stray valid/not-ready 1 expected 0"); end
    test_single_op("xor_after_reset", ALU_XOR, 32'h0000_F0F0, 32'h0000_FFFF, r);
    tests++;
    if (r !== 32'h0000_0F0F) begin fails++; $display("FAIL xor const: got %h expected 00000f0f", r); end
  endtask

  task automatic test_random();
    logic [31:0] r, a, b;
    logic [3:0]  sel;
    for (int i = 0; i < 80; i++) begin
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h7FFF_FFFF + 32'($urandom_range(0, 2));
      test_single_op($sformatf("rand%0d_sel%0d", i, sel), sel, a, b, r);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
